// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    // Run-state of the sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Fault codes reported on Fault_Code
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

endpackage

// File: rtl/fetch_seq_ras_stack.sv
// Return-address stack: LIFO register array addressed by an occupancy count.
// The parent never asserts push and pop together; clear wins over both.
module ras_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0] count_reg;
    logic [W-1:0]  entries [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    // DEPTH is a power of two, so the low bits of the count index the next free slot
    assign wr_idx  = count_reg[AW-1:0];
    assign top_idx = count_reg[AW-1:0] - AW'(1);
    assign top     = entries[top_idx];
    assign count   = count_reg;

    // Occupancy counter; storage contents need no reset because count gates them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (do_push) begin
            count_reg <= count_reg + CW'(1);
        end else if (do_pop) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] entry_reg;

            // Each slot captures din only when it is the slot being pushed into
            always_ff @(posedge clk) begin
                if (do_push && (wr_idx == AW'(gi))) begin
                    entry_reg <= din;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/fetch_seq.sv
// Next-instruction sequencer: PC update with relative/conditional branches,
// absolute jumps, call/return through a return-address stack, stall, halt
// and a run-state machine that freezes on stack overflow/underflow.
module fetch_seq #(
    parameter  int PC_W      = 8,
    parameter  int OFF_W     = 6,
    parameter  int RAS_DEPTH = 4,
    localparam int CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  Start_Addr,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Branch_Z,
    input  logic             Zero,
    input  logic [OFF_W-1:0] Offset,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Ret,
    input  logic [PC_W-1:0]  Jump_Addr,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [1:0]       Fault_Code,
    output logic [CW-1:0]    RAS_Count
);
    import fetch_pkg::*;

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [1:0]      fc_reg, fc_next;
    logic            running_reg, done_reg, fault_reg;

    logic            ras_clear, ras_push, ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_full, ras_empty;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;

    // Signed cast sign-extends the offset; adding it as PC_W bits wraps naturally
    assign off_ext = PC_W'($signed(Offset));
    assign pc_inc  = pc_reg + PC_W'(1);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (CLK),
        .rst_n (Reset_n),
        .clear (ras_clear),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .top   (ras_top),
        .count (RAS_Count),
        .full  (ras_full),
        .empty (ras_empty)
    );

    // Next-state, next-PC and stack control; Start overrides everything
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fc_next    = fc_reg;
        ras_clear  = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (Start) begin
            state_next = RUN;
            pc_next    = Start_Addr;
            fc_next    = FC_NONE;
            ras_clear  = 1'b1;
        end else if (state_reg == RUN && !Stall) begin
            if (Halt) begin
                state_next = DONE;
            end else if (Ret) begin
                if (ras_empty) begin
                    state_next = FAULT;
                    fc_next    = FC_UNF;
                end else begin
                    pc_next = ras_top;
                    ras_pop = 1'b1;
                end
            end else if (Call) begin
                if (ras_full) begin
                    state_next = FAULT;
                    fc_next    = FC_OVF;
                end else begin
                    pc_next  = Jump_Addr;
                    ras_push = 1'b1;
                end
            end else if (Jump) begin
                pc_next = Jump_Addr;
            end else if (Branch || (Branch_Z && Zero)) begin
                pc_next = pc_reg + off_ext;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    // State, PC, fault code and registered state decodes
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            fc_reg      <= FC_NONE;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            fc_reg      <= fc_next;
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
            fault_reg   <= (state_next == FAULT);
        end
    end

    assign PC         = pc_reg;
    assign Running    = running_reg;
    assign Done       = done_reg;
    assign Fault      = fault_reg;
    assign Fault_Code = fc_reg;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: the driver applies inputs on the falling
// edge and queues the reference model's expected outputs; the monitor pops
// and compares one entry after every rising edge.
module tb_fetch_seq;

    logic       CLK, Reset_n;
    logic       start, stall, branch, branch_z, zero, jump, call, ret, halt;
    logic [7:0] start_addr, jump_addr;
    logic [5:0] offset;
    logic [7:0] pc;
    logic       running, done, fault;
    logic [1:0] fault_code;
    logic [2:0] ras_count;

    typedef struct packed {
        logic [7:0] pc;
        logic       running;
        logic       done;
        logic       fault;
        logic [1:0] fc;
        logic [2:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Reference model state (own labels, plain integers and a queue for the stack)
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;
    int m_pc, m_st, m_fc;
    int m_ras[$];

    fetch_seq #(.PC_W(8), .OFF_W(6), .RAS_DEPTH(4)) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .Start      (start),
        .Start_Addr (start_addr),
        .Stall      (stall),
        .Branch     (branch),
        .Branch_Z   (branch_z),
        .Zero       (zero),
        .Offset     (offset),
        .Jump       (jump),
        .Call       (call),
        .Ret        (ret),
        .Jump_Addr  (jump_addr),
        .Halt       (halt),
        .PC         (pc),
        .Running    (running),
        .Done       (done),
        .Fault      (fault),
        .Fault_Code (fault_code),
        .RAS_Count  (ras_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic obs_t observed();
        obs_t o;
        o.pc = pc; o.running = running; o.done = done; o.fault = fault;
        o.fc = fault_code; o.cnt = ras_count;
        return o;
    endfunction

    task automatic clr();
        start = 0; stall = 0; branch = 0; branch_z = 0; zero = 0;
        jump = 0; call = 0; ret = 0; halt = 0;
        start_addr = 8'h00; jump_addr = 8'h00; offset = 6'h00;
    endtask

    task automatic model_reset();
        m_pc = 0; m_st = M_IDLE; m_fc = 0;
        m_ras.delete();
    endtask

    // Apply current inputs, predict the post-edge outputs, wait for next falling edge
    task automatic step();
        obs_t e;
        int   o;
        if (start) begin
            m_pc = start_addr; m_st = M_RUN; m_fc = 0;
            m_ras.delete();
        end else if (m_st == M_RUN && !stall) begin
            if (halt) begin
                m_st = M_DONE;
            end else if (ret) begin
                if (m_ras.size() == 0) begin
                    m_st = M_FAULT; m_fc = 2;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (call) begin
                if (m_ras.size() == 4) begin
                    m_st = M_FAULT; m_fc = 1;
                end else begin
                    m_ras.push_back((m_pc + 1) % 256);
                    m_pc = jump_addr;
                end
            end else if (jump) begin
                m_pc = jump_addr;
            end else if (branch || (branch_z && zero)) begin
                o = int'(offset);
                if (o > 31) o -= 64;
                m_pc = (m_pc + o + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
        e.pc      = 8'(m_pc);
        e.running = (m_st == M_RUN);
        e.done    = (m_st == M_DONE);
        e.fault   = (m_st == M_FAULT);
        e.fc      = 2'(m_fc);
        e.cnt     = 3'(m_ras.size());
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic check_reset(input string tag);
        obs_t got;
        got = observed();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_%s got pc=%02h run=%0b done=%0b fault=%0b fc=%02b cnt=%0d required all zero",
                     tag, got.pc, got.running, got.done, got.fault, got.fc, got.cnt);
        end else begin
            $display("reset_%s pc=%02h all outputs zero ok", tag, got.pc);
        end
    endtask

    // Reset pulse strictly between clock edges, checked before any rising edge
    task automatic async_reset();
        #2 Reset_n = 1'b0;
        #1 check_reset("async");
        #1 Reset_n = 1'b1;
        model_reset();
        clr();
        step();
    endtask

    // Monitor: one comparison per cycle that has a queued expectation
    initial begin
        obs_t e, got;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = observed();
                txn++;
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL txn%0d got pc=%02h run=%0b done=%0b fault=%0b fc=%02b cnt=%0d required pc=%02h run=%0b done=%0b fault=%0b fc=%02b cnt=%0d",
                             txn, got.pc, got.running, got.done, got.fault, got.fc, got.cnt,
                             e.pc, e.running, e.done, e.fault, e.fc, e.cnt);
                end else begin
                    $display("txn %0d pc=%02h run=%0b done=%0b fault=%0b fc=%02b cnt=%0d ok",
                             txn, got.pc, got.running, got.done, got.fault, got.fc, got.cnt);
                end
            end
        end
    end

    // Driver: directed scenarios then randomized traffic
    initial begin
        Reset_n = 1'b0;
        clr();
        model_reset();
        repeat (2) @(negedge CLK);
        check_reset("power_on");
        Reset_n = 1'b1;

        // Idle cycles before Start: PC held in IDLE
        step();
        branch = 1; offset = 6'h05; step(); clr();

        // Start at 0x10 then free-run
        start = 1; start_addr = 8'h10; step(); clr();
        repeat (3) step();

        // Conditional branch taken / not taken from 0x20
        start = 1; start_addr = 8'h20; step(); clr();
        branch_z = 1; zero = 1; offset = 6'b111100; step(); clr();
        start = 1; start_addr = 8'h20; step(); clr();
        branch_z = 1; zero = 0; offset = 6'b111100; step(); clr();

        // Call and return
        start = 1; start_addr = 8'h30; step(); clr();
        call = 1; jump_addr = 8'h80; step(); clr();
        repeat (2) step();
        jump = 1; jump_addr = 8'h90; step(); clr();
        ret = 1; step(); clr();

        // Five nested calls overflow a four-entry stack
        start = 1; start_addr = 8'h00; step(); clr();
        for (int i = 0; i < 5; i++) begin
            call = 1; jump_addr = 8'h40 + 8'(i); step(); clr();
        end
        branch = 1; offset = 6'h03; step(); clr();
        jump = 1; jump_addr = 8'h11; step(); clr();

        // Return on an empty stack underflows
        start = 1; start_addr = 8'h50; step(); clr();
        ret = 1; step(); clr();
        step();

        // Wrap, stall, Start overriding stall
        start = 1; start_addr = 8'hFF; step(); clr();
        step();
        stall = 1; branch = 1; offset = 6'h07; step(); clr();
        stall = 1; start = 1; start_addr = 8'hA5; step(); clr();
        branch = 1; offset = 6'h20; step(); clr();

        // Halt mid-run then five ignored branches
        halt = 1; step(); clr();
        for (int i = 0; i < 5; i++) begin
            branch = 1; offset = 6'h02; step(); clr();
        end

        // Asynchronous reset mid-run with a non-empty stack
        start = 1; start_addr = 8'h60; step(); clr();
        call = 1; jump_addr = 8'h70; step(); clr();
        async_reset();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            clr();
            start      = ($urandom_range(0, 99) < ((m_st == M_RUN) ? 3 : 25));
            stall      = ($urandom_range(0, 99) < 10);
            halt       = ($urandom_range(0, 99) < 2);
            ret        = ($urandom_range(0, 99) < 14);
            call       = ($urandom_range(0, 99) < 14);
            jump       = ($urandom_range(0, 99) < 8);
            branch     = ($urandom_range(0, 99) < 10);
            branch_z   = ($urandom_range(0, 99) < 20);
            zero       = 1'($urandom_range(0, 1));
            offset     = 6'($urandom);
            start_addr = 8'($urandom);
            jump_addr  = 8'($urandom);
            if (n % 137 == 136) begin
                async_reset();
            end else begin
                step();
            end
        end
        clr();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised next-instruction sequencer; the successor of the single-width PC incrementer.
- Generalises PC and branch-offset widths, adds conditional branching on Zero, absolute jumps, call/return through a hardware return-address stack (RAS), stall, halt, and a run-state machine with fault reporting.
- Sits at the head of the datapath: PC drives instruction-memory address; control inputs come from the decoder and ALU flags.

Parameters:
- PC_W, 8, program counter and address width in bits
- OFF_W, 6, signed branch offset width in bits (OFF_W <= PC_W)
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
- CLK  in  1  clock, rising-edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  load Start_Addr into PC and enter RUN
- Start_Addr  in  PC_W  program start address
- Stall  in  1  hold PC and RAS this cycle
- Branch  in  1  unconditional relative branch
- Branch_Z  in  1  relative branch taken only if Zero=1
- Zero  in  1  ALU zero flag
- Offset  in  OFF_W  signed two's-complement branch offset
- Jump  in  1  absolute jump to Jump_Addr
- Call  in  1  push PC+1, jump to Jump_Addr
- Ret  in  1  pop RAS into PC
- Jump_Addr  in  PC_W  absolute target
- Halt  in  1  stop fetching (enter DONE)
- PC  out  PC_W  current fetch address
- Running  out  1  high in RUN state
- Done  out  1  high in DONE state
- Fault  out  1  high in FAULT state
- Fault_Code  out  2  01 RAS overflow, 10 RAS underflow, 00 none
- RAS_Count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (async, Reset_n=0): PC=0, state=IDLE, RAS_Count=0, Fault_Code=00, Running=Done=Fault=0. RAS storage contents are don't-care.
- States:
  - IDLE: PC held.
  - RUN: PC updates per priority below.
  - DONE: PC held.
  - FAULT: PC held.
- Start has top priority in every state: PC<=Start_Addr, RAS_Count<=0, Fault_Code<=00, state<=RUN. It also overrides Stall.
- In RUN, the per-cycle priority after Start is:
  1. Stall: hold everything.
  2. Halt: state<=DONE, PC held.
  3. Ret:
     - RAS_Count=0: state<=FAULT, Fault_Code<=10, PC held.
     - Otherwise: PC<=top entry, RAS_Count-=1.
  4. Call:
     - RAS_Count=RAS_DEPTH: state<=FAULT, Fault_Code<=01, PC held.
     - Otherwise: push PC+1 (mod 2^PC_W), RAS_Count+=1, PC<=Jump_Addr.
  5. Jump: PC<=Jump_Addr.
  6. Branch, or (Branch_Z and Zero): PC<=PC+sext(Offset).
  7. Otherwise (including Branch_Z with Zero=0): PC<=PC+1.
- Latency: the new PC is visible one cycle after the controlling inputs are sampled.
- Arithmetic: Offset is sign-extended to PC_W; all PC arithmetic wraps modulo 2^PC_W. Example with PC_W=8: PC=0xFF plus 1 gives 0x00.
- Control inputs other than Start are ignored in IDLE, DONE and FAULT.
- Outputs Running/Done/Fault are registered decodes of the state (one-hot across RUN/DONE/FAULT; all low in IDLE).
- Fault_Code holds until the next Start or reset.
- Reset asserted mid-operation: immediate return to the reset values; no pending push/pop completes.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {IDLE, RUN, DONE, FAULT}
  - fault-code localparams FC_NONE, FC_OVF, FC_UNF
- Sub-module ras_stack (parameters DEPTH, W):
  - Interface: push, pop, din, top, count, full, empty.
  - LIFO register array with count pointer.
  - The parent guarantees that push and pop are never both asserted.

Test Plan:
- Reset then Start, Start_Addr=0x10, no controls for 3 cycles -> PC sequence 0x10,0x11,0x12,0x13; Running=1.
- PC=0x20, Branch_Z=1, Offset=6'b111100 (-4): with Zero=1 -> PC=0x1C; repeat with Zero=0 -> PC=0x21.
- PC=0x30, Call with Jump_Addr=0x80 -> PC=0x80, RAS_Count=1; later Ret -> PC=0x31, RAS_Count=0.
- RAS_DEPTH=4: five nested Calls -> fifth sets Fault=1, Fault_Code=01, PC frozen at the fourth target. Ret with empty RAS after a fresh Start -> Fault_Code=10.
- PC=0xFF with no controls -> PC=0x00. Stall=1 with Branch=1 -> PC unchanged. Start with Stall=1 -> PC=Start_Addr.
- Halt mid-run -> Done=1, PC held for 5 cycles despite Branch. Reset_n pulsed low asynchronously between clock edges -> PC=0, IDLE, RAS_Count=0 immediately.
